// File: rtl/sfp_feeder.sv
// sfp_feeder: streams psum vectors into the SFP lanes, flushes every num_acc
// vectors and writes each lane result to psum memory. Optional ReLU on the write path: SFP_FEEDER_RELU_EN.
module sfp_feeder #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 4,
    parameter int addr_bw = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [cnt_bw-1:0]        num_acc,
    input  logic [addr_bw-1:0]       num_out,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic [col*psum_bw-1:0]   lane_data,
    output logic                     lane_acc_en,
    output logic                     lane_flush_en,
    input  logic [col*psum_bw-1:0]   lane_out,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_addr,
    output logic [col*psum_bw-1:0]   mem_wdata,
    output logic                     busy,
    output logic                     done
);

    localparam int DW = col * psum_bw;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [cnt_bw-1:0]  r_acc_last;
    logic [addr_bw-1:0] r_out_last;
    logic [cnt_bw-1:0]  r_vec_cnt;
    logic [addr_bw-1:0] r_flush_cnt;
    logic [addr_bw-1:0] r_addr;
    logic               r_wen;

    logic [1:0]         w_state_nxt;
    logic               w_xfer;
    logic               w_flush;
    logic               w_last_out;
    logic               w_job_start;

    // Write-path transform; with ReLU each negative lane is replaced by zero.
    function automatic logic [DW-1:0] f_wdata(input logic [DW-1:0] d);
        logic [DW-1:0] res;
        res = d;
`ifdef SFP_FEEDER_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (d[i*psum_bw + psum_bw - 1]) begin
                res[i*psum_bw +: psum_bw] = '0;
            end else begin
                res[i*psum_bw +: psum_bw] = d[i*psum_bw +: psum_bw];
            end
        end
`endif
        return res;
    endfunction

    // Handshake and flush decode; a flush is the transfer that completes an output.
    always_comb begin
        w_job_start = (r_state == S_IDLE) && start;
        w_xfer      = in_valid && (r_state == S_ACC);
        w_flush     = w_xfer && (r_vec_cnt == r_acc_last);
        w_last_out  = (r_flush_cnt == r_out_last);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_out != '0) ? S_ACC : S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC: begin
                if (w_flush && w_last_out) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ACC;
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; the write strobe trails its flush by one cycle so lane_out is settled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wen   <= w_flush;
        end
    end

    // Job configuration, captured once per start; num_acc of 0 behaves as 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_last <= '0;
            r_out_last <= '0;
        end else if (w_job_start) begin
            r_acc_last <= (num_acc == '0) ? '0 : num_acc - cnt_bw'(1);
            r_out_last <= num_out - addr_bw'(1);
        end
    end

    // Vector, flush and address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec_cnt   <= '0;
            r_flush_cnt <= '0;
            r_addr      <= '0;
        end else if (w_job_start) begin
            r_vec_cnt   <= '0;
            r_flush_cnt <= '0;
            r_addr      <= '0;
        end else begin
            if (w_xfer) begin
                r_vec_cnt <= w_flush ? '0 : r_vec_cnt + cnt_bw'(1);
            end
            if (w_flush) begin
                r_flush_cnt <= r_flush_cnt + addr_bw'(1);
            end
            if (r_wen) begin
                r_addr <= r_addr + addr_bw'(1);
            end
        end
    end

    // Write data follows lane_out only while a write is strobed, otherwise zero.
    always_comb begin
        mem_wdata = '0;
        if (r_wen) begin
            mem_wdata = f_wdata(lane_out);
        end else begin
            mem_wdata = '0;
        end
    end

    assign in_ready      = (r_state == S_ACC);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign lane_data     = in_data;
    assign lane_acc_en   = w_xfer;
    assign lane_flush_en = w_flush;
    assign mem_wen       = r_wen;
    assign mem_addr      = r_addr;

endmodule

// File: tb/tb_sfp_feeder.sv
// Scoreboard bench for sfp_feeder with a behavioural model of the SFP lanes.
module tb_sfp_feeder;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int CBW = 4;
    localparam int ABW = 11;
    localparam int DW  = COL * PBW;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [CBW-1:0] num_acc;
    logic [ABW-1:0] num_out;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic [DW-1:0]  lane_data;
    logic           lane_acc_en;
    logic           lane_flush_en;
    logic [DW-1:0]  lane_out;
    logic           mem_wen;
    logic [ABW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    sfp_feeder #(.col(COL), .psum_bw(PBW), .cnt_bw(CBW), .addr_bw(ABW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_acc(num_acc), .num_out(num_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lane_data(lane_data), .lane_acc_en(lane_acc_en), .lane_flush_en(lane_flush_en),
        .lane_out(lane_out), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    typedef struct {
        logic [ABW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] vecs[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    logic prev_done = 1'b0;
    logic signed [PBW-1:0] acc_m [COL];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane model: accumulate on acc_en, publish the sum to lane_out on flush.
    always @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < COL; l++) acc_m[l] <= '0;
            lane_out <= '0;
        end else if (lane_acc_en) begin
            for (int l = 0; l < COL; l++) begin
                if (lane_flush_en) begin
                    lane_out[l*PBW +: PBW] <= acc_m[l] + lane_data[l*PBW +: PBW];
                    acc_m[l] <= '0;
                end else begin
                    acc_m[l] <= acc_m[l] + lane_data[l*PBW +: PBW];
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor driving the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_wen) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wen", 1, 0);
                end else begin
                    check("wr_addr", mem_addr, exp_q[0].addr);
                    check("wr_data", mem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                last_wr_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (prev_done) check("done_pulse_len", 2, 1);
            end
        end
        prev_done <= done;
    end

    task automatic build(input int n, input bit lane0_ramp);
        logic [DW-1:0] v;
        logic [PBW-1:0] t;
        vecs.delete();
        for (int k = 0; k < n; k++) begin
            for (int l = 0; l < COL; l++) begin
                t = PBW'($urandom_range(400, 0)) - 16'd200;
                if (lane0_ramp && l == 0) t = PBW'(k + 1);
                v[l*PBW +: PBW] = t;
            end
            vecs.push_back(v);
        end
    endtask

    task automatic push_expect(input int last_idx, input int eff, input int o);
        wr_t e;
        logic [DW-1:0] v;
        logic [PBW-1:0] s;
        for (int l = 0; l < COL; l++) begin
            s = '0;
            for (int j = last_idx - eff + 1; j <= last_idx; j++) begin
                v = vecs[j];
                s = s + v[l*PBW +: PBW];
            end
`ifdef SFP_FEEDER_RELU_EN
            if (s[PBW-1]) s = '0;
`endif
            e.data[l*PBW +: PBW] = s;
        end
        e.addr = ABW'(o);
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_acc_en"}, lane_acc_en, 0);
        check({tag, "_flush_en"}, lane_flush_en, 0);
        check({tag, "_wen"}, mem_wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic run_job(input int acc, input int nout, input bit gap, input bit poke, input int abort);
        int eff, idx, k, total, d0;
        bit got;
        eff = (acc == 0) ? 1 : acc;
        total = eff * nout;
        d0 = done_cnt;
        num_acc = CBW'(acc);
        num_out = ABW'(nout);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        k = 0;
        while (idx < total && k < 400) begin
            in_valid = !(gap && (k % 2 == 1));
            in_data = vecs[idx];
            if (poke && k == 1) begin
                start = 1'b1;
                num_out = '0;
                num_acc = '0;
            end
            if (in_valid && (idx % eff == eff - 1)) push_expect(idx, eff, idx / eff);
            @(negedge clk);
            check("in_ready", in_ready, 1);
            check("busy", busy, 1);
            check("lane_data", lane_data, in_data);
            check("acc_en", lane_acc_en, in_valid);
            check("flush_en", lane_flush_en, (in_valid && (idx % eff == eff - 1)) ? 1 : 0);
            if (in_valid) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (abort > 0 && idx == abort) break;
        end
        check("fed_all", idx, (abort > 0) ? abort : total);
        if (abort > 0) begin
            in_valid = 1'b1;
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("abort");
            reset = 1'b0;
            in_valid = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt - d0, 0);
            check("abort_q_empty", exp_q.size(), 0);
        end else begin
            in_valid = 1'b0;
            got = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            check("done_seen", got, 1);
            @(posedge clk); #1;
            check("done_once", done_cnt - d0, 1);
            check("done_after_wr", done_cyc - last_wr_cyc, 1);
            check("q_empty", exp_q.size(), 0);
            check("idle_after", busy, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        reset = 1'b1;
        start = 1'b0;
        num_acc = '0;
        num_out = '0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Lane0 ramp 1..6, three vectors per output: sums 6 and 15.
        build(6, 1'b1);
        run_job(3, 2, 1'b0, 1'b0, 0);

        // num_acc of 0 acts as 1: a single vector with lane0 = 7.
        build(1, 1'b0);
        v = vecs[0];
        v[PBW-1:0] = 16'd7;
        vecs[0] = v;
        run_job(0, 1, 1'b0, 1'b0, 0);

        // Empty job: done in the cycle after the start cycle, no handshake.
        num_out = '0;
        num_acc = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("n0_in_ready", in_ready, 0);
        check("n0_busy", busy, 1);
        check("n0_done", done, 1);
        @(negedge clk);
        check("n0_done_end", done, 0);
        check("n0_idle", busy, 0);
        @(posedge clk); #1;

        // Gapped valid with a start pulse inside the job that must be ignored.
        build(4, 1'b0);
        run_job(2, 2, 1'b1, 1'b1, 0);

        // Lane0 sums to -5 and lane1 to +9 over two vectors.
        vecs.delete();
        v = '0;
        v[PBW-1:0] = -16'sd2;
        v[2*PBW-1:PBW] = 16'd4;
        vecs.push_back(v);
        v[PBW-1:0] = -16'sd3;
        v[2*PBW-1:PBW] = 16'd5;
        vecs.push_back(v);
        run_job(2, 1, 1'b0, 1'b0, 0);

        // Reset after one of three vectors, then a fresh job from address 0.
        build(3, 1'b1);
        run_job(3, 2, 1'b0, 1'b0, 1);
        build(6, 1'b0);
        run_job(2, 3, 1'b0, 1'b0, 0);

        // Streaming back-to-back outputs.
        build(24, 1'b0);
        run_job(4, 6, 1'b0, 1'b0, 0);
        build(5, 1'b0);
        run_job(1, 5, 1'b0, 1'b0, 0);
        build(10, 1'b0);
        run_job(5, 2, 1'b1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
